uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, next generation of the fixed 8N1 byte receiver. Configurable data width, parity mode and stop-bit count. Adds an input synchroniser, 3-sample majority voting, start-bit glitch rejection, parity/framing error reporting and a valid/ready output register with overrun detection. Sits between the FPGA RX pin and the command parser / RX FIFO.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division; 5208 at defaults)
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked, legal 1 or 2

Ports:
i_sysclk  in  1  system clock; all logic on rising edge
i_sysrst  in  1  synchronous active-high reset
i_uart_rx  in  1  asynchronous serial line, idle high
o_rx_data  out  DATA_BITS  received word, LSB = first data bit on the line
o_rx_valid  out  1  o_rx_data and error flags valid; held until accepted
i_rx_ready  in  1  consumer accepts word when o_rx_valid & i_rx_ready
o_parity_err  out  1  parity mismatch for held word (0 when PARITY = 0)
o_frame_err  out  1  any checked stop bit sampled low for held word
o_overrun  out  1  one-cycle pulse: new frame completed while o_rx_valid still high
o_busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (synchronous, i_sysrst high at clock edge): FSM -> IDLE, all counters 0, synchroniser flops -> 1, o_rx_data = 0, o_rx_valid/o_parity_err/o_frame_err/o_overrun/o_busy = 0. Reset mid-frame discards the partial frame; no valid is produced.
- Input: 2-flop synchroniser, then 1 history flop for falling-edge detect. Edge-to-FSM latency 3 cycles.
- Bit timing: bit counter runs 0..CLKS_PER_BIT-1 per bit. Samples taken at counts M-1, M, M+1 with M = CLKS_PER_BIT/2; bit value = majority of 3.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  IDLE: on falling edge of synchronised line -> START, counter cleared.
  START: at count M+1, if majority = 1 -> IDLE (glitch rejected, no flags); else continue to end of bit -> DATA.
  DATA: shift majority bit in LSB-first; after DATA_BITS bits -> PARITY if PARITY != 0, else STOP.
  PARITY: compare majority against computed parity (odd: total ones incl. parity bit odd; even: even) -> STOP.
  STOP: for each of STOP_BITS, evaluate majority at count M+1. After last stop bit sample (no wait to bit end): load output register and -> IDLE if stop = 1, else -> WAIT_IDLE.
  WAIT_IDLE: stay until synchronised line = 1, then -> IDLE (prevents break condition retriggering).
- Output load: cycle after final stop-bit M+1 sample, o_rx_data, o_parity_err, o_frame_err are written and o_rx_valid = 1. Frames with errors are still delivered, flags set.
- Handshake: o_rx_valid falls the cycle after o_rx_valid & i_rx_ready; flags clear with it. If load and acceptance coincide, load wins: valid stays 1 with new data, no overrun.
- Overrun: load while o_rx_valid = 1 and i_rx_ready = 0 -> new word and flags overwrite, o_rx_valid stays 1, o_overrun pulses 1 cycle.
- Back-to-back frames: next start edge accepted from IDLE immediately after stop-bit sample; no dead time beyond half a bit.
- o_busy = (state != IDLE).

Test Plan:
- Defaults 8N1, reset released, send 0x55 at 5208 clk/bit, ready held 1 -> one valid, o_rx_data = 0x55, no error flags; then 0xAA -> 0xAA.
- Send 0x55 then 0xAA back-to-back, i_rx_ready = 0 -> o_overrun pulses once at second load, o_rx_data = 0xAA, valid still 1; raise ready -> valid drops next cycle.
- Line low for 1000 cycles then high -> no valid, FSM back to IDLE, o_busy falls by count M+1 of start bit.
- PARITY = 2, DATA_BITS = 7, send 0x41 with parity bit 1 (wrong) -> valid, data 0x41, o_parity_err = 1; correct parity 0 -> o_parity_err = 0.
- Break: line low for 12 bit times -> one valid with data 0x00, o_frame_err = 1; no further valid until line high and a new start bit is sent; STOP_BITS = 2 with second stop low -> o_frame_err = 1.
- Assert i_sysrst for 1 cycle mid-DATA of 0xC3 -> outputs 0, no valid for that frame; next full 0x3C frame received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised, 3-sample majority-voted line sampling with
// configurable data width, parity and stop bits, and a valid/ready output register.
module uart_rx_param #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_sysclk,
    input  logic                 i_sysrst,
    input  logic                 i_uart_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int MID_CNT      = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] SMP_A     = CNT_W'(MID_CNT - 1);
    localparam logic [CNT_W-1:0] SMP_B     = CNT_W'(MID_CNT);
    localparam logic [CNT_W-1:0] SMP_END   = CNT_W'(MID_CNT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    // Odd mode wants an odd count of ones over data plus parity bit, even mode an even count.
    function automatic logic parity_err_f(input logic [DATA_BITS-1:0] data, input logic par_bit);
        logic ones_odd;
        ones_odd = (^data) ^ par_bit;
        case (PARITY)
            1:       parity_err_f = ~ones_odd;
            2:       parity_err_f = ones_odd;
            default: parity_err_f = 1'b0;
        endcase
    endfunction

    state_t                 state_r, state_n;
    logic [CNT_W-1:0]       cnt_r, cnt_n;
    logic [3:0]             idx_r, idx_n;
    logic                   sync1_r, sync2_r, hist_r;
    logic                   smp_a_r, smp_a_n, smp_b_r, smp_b_n;
    logic [DATA_BITS-1:0]   shift_r, shift_n;
    logic                   par_bit_r, par_bit_n;
    logic                   ferr_acc_r, ferr_acc_n;
    logic                   maj_s, fall_s, smp_end_s, bit_end_s, load_s, load_ferr_s;

    logic [DATA_BITS-1:0]   rx_data_r;
    logic                   rx_valid_r, parity_err_r, frame_err_r, overrun_r, busy_r;

    assign maj_s       = (smp_a_r & smp_b_r) | (smp_a_r & sync2_r) | (smp_b_r & sync2_r);
    assign fall_s      = hist_r & ~sync2_r;
    assign smp_end_s   = (cnt_r == SMP_END);
    assign bit_end_s   = (cnt_r == BIT_LAST);
    assign load_ferr_s = ferr_acc_r | ~maj_s;

    // Two-flop synchroniser plus history flop for start-edge detection.
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            hist_r  <= 1'b1;
        end else begin
            sync1_r <= i_uart_rx;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // FSM state, bit timing counters and frame assembly registers.
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            idx_r      <= 4'd0;
            smp_a_r    <= 1'b1;
            smp_b_r    <= 1'b1;
            shift_r    <= '0;
            par_bit_r  <= 1'b0;
            ferr_acc_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            idx_r      <= idx_n;
            smp_a_r    <= smp_a_n;
            smp_b_r    <= smp_b_n;
            shift_r    <= shift_n;
            par_bit_r  <= par_bit_n;
            ferr_acc_r <= ferr_acc_n;
        end
    end

    // Next-state logic; the third vote is the live synchronised line at count M+1.
    always_comb begin
        state_n    = state_r;
        cnt_n      = '0;
        idx_n      = idx_r;
        shift_n    = shift_r;
        par_bit_n  = par_bit_r;
        ferr_acc_n = ferr_acc_r;
        load_s     = 1'b0;
        if (cnt_r == SMP_A) smp_a_n = sync2_r;
        else                smp_a_n = smp_a_r;
        if (cnt_r == SMP_B) smp_b_n = sync2_r;
        else                smp_b_n = smp_b_r;
        if (bit_end_s) cnt_n = '0;
        else           cnt_n = cnt_r + CNT_W'(1);

        case (state_r)
            ST_IDLE: begin
                cnt_n      = '0;
                idx_n      = 4'd0;
                ferr_acc_n = 1'b0;
                if (fall_s) state_n = ST_START;
                else        state_n = ST_IDLE;
            end
            ST_START: begin
                if (smp_end_s && maj_s) state_n = ST_IDLE;
                else if (bit_end_s)     state_n = ST_DATA;
                else                    state_n = ST_START;
            end
            ST_DATA: begin
                if (smp_end_s) shift_n = {maj_s, shift_r[DATA_BITS-1:1]};
                else           shift_n = shift_r;
                if (bit_end_s && (idx_r == LAST_DATA)) begin
                    idx_n   = 4'd0;
                    state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end else if (bit_end_s) begin
                    idx_n   = idx_r + 4'd1;
                    state_n = ST_DATA;
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (smp_end_s) par_bit_n = maj_s;
                else           par_bit_n = par_bit_r;
                if (bit_end_s) state_n = ST_STOP;
                else           state_n = ST_PARITY;
            end
            ST_STOP: begin
                // The last stop bit ends the frame at its sample point, leaving
                // half a bit of slack for the next start edge.
                if (smp_end_s && (idx_r == LAST_STOP)) begin
                    load_s     = 1'b1;
                    ferr_acc_n = load_ferr_s;
                    cnt_n      = '0;
                    idx_n      = 4'd0;
                    state_n    = maj_s ? ST_IDLE : ST_WAIT_IDLE;
                end else if (smp_end_s) begin
                    ferr_acc_n = load_ferr_s;
                    state_n    = ST_STOP;
                end else if (bit_end_s) begin
                    idx_n   = idx_r + 4'd1;
                    state_n = ST_STOP;
                end else begin
                    state_n = ST_STOP;
                end
            end
            ST_WAIT_IDLE: begin
                cnt_n = '0;
                if (sync2_r) state_n = ST_IDLE;
                else         state_n = ST_WAIT_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // Output holding register with valid/ready handshake; a new load beats acceptance.
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            rx_data_r    <= '0;
            rx_valid_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            busy_r <= (state_n != ST_IDLE);
            if (load_s) begin
                rx_data_r    <= shift_r;
                parity_err_r <= parity_err_f(shift_r, par_bit_r);
                frame_err_r  <= load_ferr_s;
                rx_valid_r   <= 1'b1;
                overrun_r    <= rx_valid_r & ~i_rx_ready;
            end else if (rx_valid_r && i_rx_ready) begin
                rx_valid_r   <= 1'b0;
                parity_err_r <= 1'b0;
                frame_err_r  <= 1'b0;
                overrun_r    <= 1'b0;
            end else begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign o_rx_data    = rx_data_r;
    assign o_rx_valid   = rx_valid_r;
    assign o_parity_err = parity_err_r;
    assign o_frame_err  = frame_err_r;
    assign o_overrun    = overrun_r;
    assign o_busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 instance and a 7E2 instance at 16 clocks per bit,
// frames modelled from the line-level rules and compared by a decoupled monitor.
module tb_uart_rx_param;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       srst;
    logic       a_rx, a_rdy, b_rx, b_rdy;
    logic [7:0] a_data;
    logic [6:0] b_data;
    logic       a_valid, a_perr, a_ferr, a_ovr, a_busy;
    logic       b_valid, b_perr, b_ferr, b_ovr, b_busy;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .i_sysclk(clk), .i_sysrst(srst), .i_uart_rx(a_rx), .o_rx_data(a_data), .o_rx_valid(a_valid),
        .i_rx_ready(a_rdy), .o_parity_err(a_perr), .o_frame_err(a_ferr), .o_overrun(a_ovr), .o_busy(a_busy));

    uart_rx_param #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .i_sysclk(clk), .i_sysrst(srst), .i_uart_rx(b_rx), .o_rx_data(b_data), .o_rx_valid(b_valid),
        .i_rx_ready(b_rdy), .o_parity_err(b_perr), .o_frame_err(b_ferr), .o_overrun(b_ovr), .o_busy(b_busy));

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    int   ovr_cnt [2];
    logic pv [2];
    logic pa [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: what a receiver must report for the bits actually put on the line.
    function automatic exp_t model(input int inst, input logic [8:0] d, input logic pbit, input logic [1:0] stops);
        exp_t e;
        int   nb, ones;
        nb     = (inst == 0) ? 8 : 7;
        e.data = d & ((9'h001 << nb) - 9'h001);
        ones   = $countones(e.data) + ((inst == 1) ? int'(pbit) : 0);
        e.perr = (inst == 1) ? ((ones % 2) != 0) : 1'b0;
        e.ferr = (stops[0] == 1'b0) || ((inst == 1) && (stops[1] == 1'b0));
        return e;
    endfunction

    task automatic set_line(input int inst, input logic v);
        if (inst == 0) a_rx = v;
        else           b_rx = v;
    endtask

    task automatic drive_bit(input int inst, input logic v);
        set_line(inst, v);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int inst, input logic [8:0] d, input logic pflip, input logic [1:0] stops);
        int   nb, ns;
        logic pbit;
        exp_t e;
        nb   = (inst == 0) ? 8 : 7;
        ns   = (inst == 0) ? 1 : 2;
        pbit = (^d[6:0]) ^ pflip;
        e    = model(inst, d, pbit, stops);
        if (inst == 0) q_a.push_back(e);
        else           q_b.push_back(e);
        drive_bit(inst, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(inst, d[i]);
        if (inst == 1) drive_bit(inst, pbit);
        for (int s = 0; s < ns; s++) drive_bit(inst, stops[s]);
        set_line(inst, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (((q_a.size() + q_b.size()) != 0) && (n < 4000)) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", q_a.size() + q_b.size(), 0);
    endtask

    // A new word is presented on a valid rise, after an accepted word, or with an overrun pulse.
    task automatic mon(input int i);
        logic       v, r, o, pe, fe;
        logic [8:0] d;
        int         qs;
        exp_t       e;
        if (i == 0) begin
            v = a_valid; r = a_rdy; o = a_ovr; pe = a_perr; fe = a_ferr; d = {1'b0, a_data}; qs = q_a.size();
        end else begin
            v = b_valid; r = b_rdy; o = b_ovr; pe = b_perr; fe = b_ferr; d = {2'b00, b_data}; qs = q_b.size();
        end
        if (o) ovr_cnt[i]++;
        if (v && (!pv[i] || pa[i] || o)) begin
            if (qs == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid inst=%0d actual=%0h required=none", i, d);
            end else begin
                if (i == 0) e = q_a.pop_front();
                else        e = q_b.pop_front();
                check($sformatf("data_%0d", i), d, e.data);
                check($sformatf("perr_%0d", i), pe, e.perr);
                check($sformatf("ferr_%0d", i), fe, e.ferr);
            end
        end
        pv[i] = v;
        pa[i] = v & r;
    endtask

    initial begin
        pv[0] = 1'b0; pv[1] = 1'b0; pa[0] = 1'b0; pa[1] = 1'b0;
        ovr_cnt[0] = 0; ovr_cnt[1] = 0;
        forever begin
            @(posedge clk);
            #1;
            mon(0);
            mon(1);
        end
    end

    initial begin
        int       ovr_base;
        logic     saw_busy;
        logic [1:0] st;
        int       gap;

        srst = 1'b1; a_rx = 1'b1; b_rx = 1'b1; a_rdy = 1'b1; b_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_valid", a_valid, 0);
        check("rst_a_data", a_data, 0);
        check("rst_a_perr", a_perr, 0);
        check("rst_a_ferr", a_ferr, 0);
        check("rst_a_ovr", a_ovr, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_b_busy", b_busy, 0);
        @(negedge clk);
        srst = 1'b0;
        idle(2 * CPB);

        // Basic 8N1 reception, with and without idle gap.
        send_frame(0, 9'h055, 1'b0, 2'b11);
        idle(CPB);
        send_frame(0, 9'h0AA, 1'b0, 2'b11);
        drain();

        // Overrun: two back-to-back frames with the consumer stalled.
        a_rdy    = 1'b0;
        ovr_base = ovr_cnt[0];
        send_frame(0, 9'h055, 1'b0, 2'b11);
        send_frame(0, 9'h0AA, 1'b0, 2'b11);
        drain();
        @(posedge clk);
        #1;
        check("ovr_count", ovr_cnt[0] - ovr_base, 1);
        check("ovr_valid_held", a_valid, 1);
        check("ovr_data", a_data, 8'hAA);
        @(negedge clk);
        a_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("accept_valid_drop", a_valid, 0);
        @(negedge clk);
        idle(CPB);

        // Short low pulse must be rejected as a glitch.
        a_rx = 1'b0;
        idle(4);
        a_rx     = 1'b1;
        saw_busy = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            saw_busy = saw_busy | a_busy;
        end
        check("glitch_busy_seen", saw_busy, 1);
        check("glitch_busy_fall", a_busy, 0);
        idle(CPB);
        drain();

        // Even parity, 7 data bits: wrong then correct parity bit.
        send_frame(1, 9'h041, 1'b1, 2'b11);
        idle(CPB);
        send_frame(1, 9'h041, 1'b0, 2'b11);
        idle(CPB);
        // Second stop low, then first stop low.
        send_frame(1, 9'h02D, 1'b0, 2'b01);
        idle(CPB);
        send_frame(1, 9'h013, 1'b0, 2'b10);
        idle(CPB);
        drain();

        // Break: line held low for 12 bit times.
        q_a.push_back(model(0, 9'h000, 1'b0, 2'b00));
        a_rx = 1'b0;
        idle(12 * CPB);
        drain();
        check("break_wait_busy", a_busy, 1);
        a_rx = 1'b1;
        idle(CPB);
        check("break_released_busy", a_busy, 0);
        send_frame(0, 9'h05A, 1'b0, 2'b11);
        idle(CPB);
        drain();

        // Reset in the middle of the data bits of 0xC3.
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, ((8'hC3 >> i) & 8'h01) != 8'h00);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        a_rx = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid", a_valid, 0);
        check("midrst_busy", a_busy, 0);
        check("midrst_data", a_data, 0);
        @(negedge clk);
        idle(2 * CPB);
        send_frame(0, 9'h03C, 1'b0, 2'b11);
        idle(CPB);
        drain();

        // Randomised traffic on both receivers.
        for (int n = 0; n < 16; n++) begin
            st  = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b11;
            send_frame(0, 9'($urandom_range(0, 255)), 1'b0, st);
            gap = (st[0] == 1'b0) ? CPB : $urandom_range(0, CPB);
            idle(gap);
        end
        for (int n = 0; n < 16; n++) begin
            st  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            send_frame(1, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), st);
            gap = (st[1] == 1'b0) ? CPB : $urandom_range(0, CPB);
            idle(gap);
        end
        drain();
        idle(2 * CPB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
